// File: rtl/dds_addr_gen_pkg.sv
// rtl/dds_addr_gen_pkg.sv - shared widths, reset constants and helpers for the DDS address generator
package dds_addr_gen_pkg;

  localparam int ACC_W  = 24;
  localparam int ADDR_W = 10;
  localparam int DIV_W  = 16;
  localparam logic [DIV_W-1:0] DIV_RST = 16'd2500;

  // A divider period of 0 or 1 both mean "strobe every cycle".
  function automatic logic [DIV_W-1:0] norm_div(input logic [DIV_W-1:0] d);
    logic [DIV_W-1:0] one;
    one = {{(DIV_W-1){1'b0}}, 1'b1};
    return (d < 2) ? one : d;
  endfunction

endpackage

// File: rtl/dds_addr_gen_sample_pacer.sv
// rtl/dds_addr_gen_sample_pacer.sv - programmable-period tick generator (divider counter plus boundary pulse)
import dds_addr_gen_pkg::*;

module sample_pacer #(
  parameter int W = DIV_W
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] div_cnt;
  logic         last;

  // Compared with >= so a zero period still behaves as a period of one.
  assign last = ({1'b0, div_cnt} + {{W{1'b0}}, 1'b1}) >= {1'b0, period};
  assign tick = enable && last;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= last ? '0 : div_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/dds_addr_gen.sv
// rtl/dds_addr_gen.sv - DDS phase accumulator producing ROM address and sample strobe
import dds_addr_gen_pkg::*;

module dds_addr_gen (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              enable,
  input  logic [ACC_W-1:0]  tw_in,
  input  logic [DIV_W-1:0]  div_in,
  input  logic              cfg_valid,
  output logic              cfg_ack,
  output logic              sample_en,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] tw_act;
  logic [ACC_W-1:0] tw_shd;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] div_shd;
  logic             pend;
  logic             boundary;
  logic             capture;
  logic [ACC_W:0]   sum;

  sample_pacer #(.W(DIV_W)) u_pacer (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .enable   (enable),
    .period   (div_act),
    .tick     (boundary)
  );

  assign capture = cfg_valid && !pend;
  assign sum     = {1'b0, acc} + {1'b0, tw_act};

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      acc       <= '0;
      tw_act    <= '0;
      div_act   <= DIV_RST;
      tw_shd    <= '0;
      div_shd   <= '0;
      pend      <= 1'b0;
      cfg_ack   <= 1'b0;
      sample_en <= 1'b0;
      addr      <= '0;
      wrap      <= 1'b0;
    end else begin
      cfg_ack   <= capture;
      sample_en <= boundary;
      wrap      <= 1'b0;
      if (boundary) begin
        acc  <= sum[ACC_W-1:0];
        addr <= sum[ACC_W-1 -: ADDR_W];
        wrap <= sum[ACC_W];
        // Only a config captured before this cycle is applied; a same-cycle capture waits a period.
        if (pend) begin
          tw_act  <= tw_shd;
          div_act <= div_shd;
          pend    <= 1'b0;
        end
      end
      if (capture) begin
        tw_shd  <= tw_in;
        div_shd <= norm_div(div_in);
        pend    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dds_addr_gen.sv
// tb/tb_dds_addr_gen.sv - self-checking bench for dds_addr_gen with a behavioural reference model
module tb_dds_addr_gen;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        enable;
  logic [23:0] tw_in;
  logic [15:0] div_in;
  logic        cfg_valid;
  logic        cfg_ack;
  logic        sample_en;
  logic [9:0]  addr;
  logic        wrap;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  dds_addr_gen dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .enable    (enable),
    .tw_in     (tw_in),
    .div_in    (div_in),
    .cfg_valid (cfg_valid),
    .cfg_ack   (cfg_ack),
    .sample_en (sample_en),
    .addr      (addr),
    .wrap      (wrap)
  );

  // Reference model: phase as an integer modulo 2^24, period as a count of enabled cycles.
  longint unsigned m_acc;
  int unsigned m_tw, m_per, m_elapsed, m_new_tw, m_new_per;
  bit          m_pend;
  bit          e_ack, e_se, e_wrap;
  int unsigned e_addr;

  task automatic model_edge();
    bit take, boundary;
    if (reset) begin
      m_acc = 0; m_tw = 0; m_per = 2500; m_elapsed = 0;
      m_new_tw = 0; m_new_per = 0; m_pend = 0;
      e_ack = 0; e_se = 0; e_wrap = 0; e_addr = 0;
    end else begin
      take     = cfg_valid && !m_pend;
      boundary = 0;
      if (enable) begin
        m_elapsed++;
        if (m_elapsed >= m_per) begin
          boundary  = 1;
          m_elapsed = 0;
        end
      end
      e_se   = boundary;
      e_wrap = 0;
      if (boundary) begin
        m_acc  = m_acc + m_tw;
        e_wrap = (m_acc >= 64'd16777216);
        m_acc  = m_acc % 64'd16777216;
        e_addr = int'(m_acc / 64'd16384);
        if (m_pend) begin
          m_tw   = m_new_tw;
          m_per  = m_new_per;
          m_pend = 0;
        end
      end
      if (take) begin
        m_new_tw  = tw_in;
        m_new_per = (div_in < 2) ? 1 : div_in;
        m_pend    = 1;
      end
      e_ack = take;
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    model_edge();
    #1;
    chk("outputs{ack,se,wrap,addr}", {cfg_ack, sample_en, wrap, addr},
        {e_ack, e_se, e_wrap, e_addr[9:0]});
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sample_en && n < 3000);
    if (!sample_en) chk("strobe_timeout", 0, 1);
  endtask

  task automatic load_cfg(input logic [23:0] tw, input logic [15:0] dv);
    cfg_valid = 1; tw_in = tw; div_in = dv;
    step();
    chk("cfg_ack_latency", cfg_ack, 1);
    cfg_valid = 0;
  endtask

  typedef struct {
    logic [23:0] tw;
    logic [15:0] dv;
    int          exp_period;
    int          exp_step;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    int n, a1, a2, wraps, cnt;

    vecs[0] = '{24'h004000, 16'd4, 4, 1};
    vecs[1] = '{24'h800000, 16'd1, 1, 512};
    vecs[2] = '{24'h010000, 16'd2, 2, 4};
    vecs[3] = '{24'h008000, 16'd0, 1, 2};
    vecs[4] = '{24'h0FC000, 16'd7, 7, 63};
    vecs[5] = '{24'h000000, 16'd5, 5, 0};

    reset = 1; enable = 0; cfg_valid = 0; tw_in = 0; div_in = 0;
    step(); step();
    chk("reset_se", sample_en, 0);
    chk("reset_addr", addr, 0);
    reset = 0; enable = 1;

    // Defaults: 2500-cycle period, address parked at zero.
    wait_strobe(n);
    chk("default_first_period", n, 2500);
    wait_strobe(n);
    chk("default_period", n, 2500);
    chk("default_addr", addr, 0);

    for (int i = 0; i < 6; i++) begin
      load_cfg(vecs[i].tw, vecs[i].dv);
      wait_strobe(n);
      wait_strobe(n);
      chk("vec_period", n, vecs[i].exp_period);
      a1 = addr;
      wait_strobe(n);
      chk("vec_period2", n, vecs[i].exp_period);
      a2 = addr;
      chk("vec_addr_step", (a2 - a1) & 1023, vecs[i].exp_step);
    end

    // One full address revolution at step 1 gives exactly one wrap.
    load_cfg(24'h004000, 16'd4);
    wait_strobe(n);
    wraps = 0;
    for (int i = 0; i < 1024; i++) begin
      wait_strobe(n);
      if (wrap) wraps++;
    end
    chk("wraps_per_1024", wraps, 1);

    // Second request while pending is not acknowledged until the boundary clears pend.
    load_cfg(24'h008000, 16'd6);
    cfg_valid = 1; tw_in = 24'h00C000; div_in = 16'd3;
    cnt = 0;
    step();
    chk("no_ack_while_pend", cfg_ack, 0);
    while (!cfg_ack && cnt < 3000) begin
      a1 = sample_en;
      step();
      cnt++;
    end
    chk("ack_after_boundary", a1, 1);
    cfg_valid = 0;
    wait_strobe(n);
    wait_strobe(n);
    chk("second_cfg_period", n, 3);

    // Capture in the boundary cycle: old period runs once more.
    wait_strobe(n);
    step(); step();
    cfg_valid = 1; tw_in = 24'h004000; div_in = 16'd8;
    step();
    chk("collision_ack", cfg_ack, 1);
    chk("collision_strobe", sample_en, 1);
    cfg_valid = 0;
    wait_strobe(n);
    chk("collision_old_period", n, 3);
    wait_strobe(n);
    chk("collision_new_period", n, 8);

    // Freeze for 37 cycles mid-period.
    step(); step(); step();
    enable = 0;
    for (int i = 0; i < 37; i++) step();
    enable = 1;
    wait_strobe(n);
    chk("freeze_period", 3 + 37 + n, 8 + 37);
    wait_strobe(n);
    chk("after_freeze_period", n, 8);

    // Randomised run against the model.
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      if (!cfg_valid && $urandom_range(0, 19) == 0) begin
        cfg_valid = 1;
        tw_in     = $urandom() & 24'hFFFFFF;
        div_in    = 16'($urandom_range(0, 8));
      end
      step();
      if (cfg_valid && e_ack) cfg_valid = 0;
    end
    cfg_valid = 0; enable = 1;

    // Reset mid-period with a pending config.
    load_cfg(24'h100000, 16'd9);
    step(); step();
    reset = 1;
    step();
    chk("rst_ack", cfg_ack, 0);
    chk("rst_se", sample_en, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wrap", wrap, 0);
    reset = 0;
    wait_strobe(n);
    chk("rst_period_reload", n, 2500);
    chk("rst_acc_cleared", addr, 0);
    wait_strobe(n);
    chk("rst_pend_cleared", n, 2500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
